stopwatch_key_ctrl: RTL and testbench
=====================================

Name: stopwatch_key_ctrl

Overview:
- Upstream neighbour of the stopwatch counter/display control stage.
- Debounces three raw push-buttons (start/stop, pause, clear) on the system clock.
- Runs the stopwatch mode FSM and drives the `sw_en`, `pause` and `clear` levels consumed by the 100 Hz counter stage.
- `clear` is stretched so the 100 Hz-clocked consumer is guaranteed to sample it.

Parameters:
- DEBOUNCE_CYCLES, 2000000, consecutive stable clk cycles needed to accept a key level change (20 ms at 100 MHz).
- CLEAR_CYCLES, 2000000, clk cycles `clear` is held high; must cover at least two 100 Hz periods.
- CNT_W, 21, width of the debounce and clear counters; must hold max(DEBOUNCE_CYCLES, CLEAR_CYCLES)-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_start  input  1  raw start/stop button, active-high, asynchronous, bouncy.
- key_pause  input  1  raw pause (lap-hold) button, active-high, asynchronous.
- key_clear  input  1  raw clear button, active-high, asynchronous.
- sw_en  output  1  counting enable level to the counter stage.
- pause  output  1  display-freeze level to the counter stage; counting continues.
- clear  output  1  clear level to the counter stage, stretched.
- state  output  3  current FSM state encoding, for LEDs and debug.

Behaviour:
- Clocking and reset
  - One clock: `clk`. Reset is asynchronous and active-low on `rst_n`.
  - All flops in the block reset on that reset.
- Reset values
  - State = IDLE; `sw_en` = 0, `pause` = 0, `clear` = 0, `state` = 3'd0.
  - Synchronizers, debounced levels, counters and press pulses are all 0.
- Per-key path (identical for all three keys)
  - 2-flop synchronizer feeds a debounce counter.
  - Debounce counter:
    - Increments every cycle the synced level differs from the debounced level.
    - Resets to 0 on any cycle they are equal.
    - On the cycle it equals DEBOUNCE_CYCLES-1 with the levels still differing: debounced level <= synced level, and the counter goes to 0.
  - Press pulse: registered, exactly 1 cycle wide, on a 0->1 transition of the debounced level. Releases produce no event.
- Key latency
  - Raw edge to press pulse: DEBOUNCE_CYCLES+3 clk edges.
  - Press pulse to new outputs: 1 edge.
- Key held through reset
  - If a key is held when reset deasserts, it is accepted as a press after debounce.
- FSM states (`state` encoding) and outputs
  - IDLE (0): `sw_en` = 0, `pause` = 0, `clear` = 0.
  - RUN (1): `sw_en` = 1, `pause` = 0, `clear` = 0.
  - HOLD (2): `sw_en` = 1, `pause` = 1, `clear` = 0.
  - STOP (3): `sw_en` = 0, `pause` = 0, `clear` = 0.
  - CLEAR (4): `sw_en` = 0, `pause` = 0, `clear` = 1.
- Outputs are registered and change on the same edge as `state`.
- Transitions, on press pulses:
  - start press:
    - IDLE -> RUN; STOP -> RUN.
    - RUN -> STOP; HOLD -> STOP (drops `pause` so the display catches up).
  - pause press:
    - RUN -> HOLD; HOLD -> RUN.
    - Ignored in IDLE, STOP and CLEAR.
  - clear press: any state except CLEAR -> CLEAR, and the clear counter is loaded with 0.
  - CLEAR:
    - Clear counter increments each cycle.
    - At CLEAR_CYCLES-1 the FSM goes to IDLE.
    - `clear` is high for exactly CLEAR_CYCLES cycles.
- Simultaneous press pulses in one cycle
  - Priority: clear > start > pause.
  - Lower-priority pulses that cycle are discarded, not queued.
- Presses during CLEAR
  - All ignored and discarded.
  - Debouncing continues, so a key still held after CLEAR generates no new event until it is released and pressed again.
- Reset mid-operation
  - Any state, including mid-CLEAR, goes immediately to IDLE.
  - `clear` drops asynchronously; all counters zero.
- No illegal-state lockup
  - Unused encodings 5–7 go to IDLE on the next edge with all outputs 0.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8.
1. Reset release, no keys -> `sw_en` = `pause` = `clear` = 0 and `state` = 0 for 100 cycles.
2. Clean start press held 20 cycles -> `sw_en` rises exactly 8 edges after the raw rise (DEBOUNCE_CYCLES+4) and `state` = 1; a second press gives `state` = 3 and `sw_en` = 0.
3. Bouncy start input toggling every 2 cycles for 30 cycles, then stable high -> exactly one press accepted (`state` IDLE -> RUN once); no event on release.
4. In RUN, pause press -> `state` = 2 with `sw_en` = 1, `pause` = 1; pause again -> `state` = 1; in HOLD, start press -> `state` = 3 with `pause` = 0.
5. In RUN, start and clear pressed in the same cycle -> `state` = 4 with `clear` high for exactly 8 cycles, then `state` = 0; a start press made during CLEAR is ignored.
6. `rst_n` asserted on the 3rd cycle of CLEAR -> `clear` = 0 immediately (asynchronously), `state` = 0; after release, a held key_pause causes no transition from IDLE.

Source files
------------

// File: rtl/stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_key_ctrl
//
// Purpose:
//   Front end of the stopwatch. Synchronises and debounces the three raw
//   push-buttons, turns debounced presses into one-cycle pulses, and runs the
//   stopwatch mode FSM. The FSM drives the level signals that the 100 Hz
//   counter/display stage samples. `clear` is stretched over CLEAR_CYCLES so
//   the slow consumer always sees it.
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst_n      in   asynchronous active-low reset
//   key_start  in   raw start/stop button, active-high, bouncy
//   key_pause  in   raw pause (lap-hold) button, active-high
//   key_clear  in   raw clear button, active-high
//   sw_en      out  counting enable level
//   pause      out  display-freeze level (counting continues)
//   clear      out  stretched clear level
//   state      out  current FSM state encoding (LEDs / debug)
// -----------------------------------------------------------------------------
module stopwatch_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned CLEAR_CYCLES    = 2000000,
    parameter int unsigned CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_clear,
    output logic       sw_en,
    output logic       pause,
    output logic       clear,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int K_START = 0;
    localparam int K_PAUSE = 1;
    localparam int K_CLEAR = 2;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       key_raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       db;       // debounced levels
    logic [2:0]       db_d;     // debounced levels delayed, for edge detect
    logic [2:0]       press;    // registered one-cycle press pulses
    logic [CNT_W-1:0] db_cnt [3];

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] clr_cnt;
    logic [CNT_W-1:0] clr_cnt_nxt;
    logic             sw_en_nxt;
    logic             pause_nxt;
    logic             clear_nxt;

    assign key_raw = {key_clear, key_pause, key_start};

    // -------------------------------------------------------------------------
    // Per-key synchroniser, debounce counter and press pulse.
    // A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles
    // of disagreement; any agreeing cycle restarts the count.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM: state register plus registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            clr_cnt <= '0;
            sw_en   <= 1'b0;
            pause   <= 1'b0;
            clear   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            sw_en   <= sw_en_nxt;
            pause   <= pause_nxt;
            clear   <= clear_nxt;
        end
    end

    // Next state. Priority clear > start > pause; losing pulses are dropped.
    // All presses are ignored while CLEAR is running.
    always_comb begin
        state_nxt   = state_q;
        clr_cnt_nxt = '0;
        case (state_q)
            ST_IDLE: begin
                if (press[K_CLEAR])      state_nxt = ST_CLEAR;
                else if (press[K_START]) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (press[K_CLEAR])      state_nxt = ST_CLEAR;
                else if (press[K_START]) state_nxt = ST_STOP;
                else if (press[K_PAUSE]) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Leaving HOLD via start drops pause so the display catches up.
                if (press[K_CLEAR])      state_nxt = ST_CLEAR;
                else if (press[K_START]) state_nxt = ST_STOP;
                else if (press[K_PAUSE]) state_nxt = ST_RUN;
            end
            ST_STOP: begin
                if (press[K_CLEAR])      state_nxt = ST_CLEAR;
                else if (press[K_START]) state_nxt = ST_RUN;
            end
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
                else                     clr_cnt_nxt = clr_cnt + CNT_ONE;
            end
            default: state_nxt = ST_IDLE;   // unused encodings recover
        endcase
    end

    // Outputs are decoded from the next state so they switch with `state`.
    always_comb begin
        sw_en_nxt = 1'b0;
        pause_nxt = 1'b0;
        clear_nxt = 1'b0;
        case (state_nxt)
            ST_RUN:   sw_en_nxt = 1'b1;
            ST_HOLD: begin
                sw_en_nxt = 1'b1;
                pause_nxt = 1'b1;
            end
            ST_CLEAR: clear_nxt = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_key_ctrl
//
// Directed bench for stopwatch_key_ctrl with DEBOUNCE_CYCLES=4 and
// CLEAR_CYCLES=8. Inputs change and outputs are sampled 1 ns after the
// rising edge. Expected values are hand-derived: a raw key edge shows up on
// the outputs 8 edges later (2 sync + 4 debounce + 1 pulse + 1 state).
// -----------------------------------------------------------------------------
module tb_stopwatch_key_ctrl;

    localparam int DB  = 4;
    localparam int CLR = 8;

    logic       clk;
    logic       rst_n;
    logic       key_start;
    logic       key_pause;
    logic       key_clear;
    logic       sw_en;
    logic       pause;
    logic       clear;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    stopwatch_key_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CLEAR_CYCLES   (CLR),
        .CNT_W          (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_start(key_start),
        .key_pause(key_pause),
        .key_clear(key_clear),
        .sw_en    (sw_en),
        .pause    (pause),
        .clear    (clear),
        .state    (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full press: hold 10 cycles (past the 8-edge latency), release 10 cycles
    // so the debounced level returns low before the next press.
    task automatic press_key(input int idx);
        case (idx)
            0: key_start = 1'b1;
            1: key_pause = 1'b1;
            default: key_clear = 1'b1;
        endcase
        tick(10);
        key_start = 1'b0;
        key_pause = 1'b0;
        key_clear = 1'b0;
        tick(10);
    endtask

    function automatic logic [5:0] outs(input logic s, input logic p, input logic c,
                                        input logic [2:0] st);
        return {s, p, c, st};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic k;
        logic [2:0] e;

        rst_n     = 1'b0;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_clear = 1'b0;
        tick(3);
        check("reset_outs", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd0));
        rst_n = 1'b1;

        // 1: idle for 100 cycles, nothing moves
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("idle_hold", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd0));
        end

        // 2: clean start press, exact latency
        key_start = 1'b1;
        tick(7);
        check("start_lat_edge7", {sw_en, state}, {1'b0, 3'd0});
        tick(1);
        check("start_lat_edge8", {sw_en, state}, {1'b1, 3'd1});
        tick(12);
        key_start = 1'b0;
        tick(10);
        check("start_release_run", {sw_en, pause, clear, state}, outs(1, 0, 0, 3'd1));
        press_key(0);
        check("start_again_stop", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd3));

        // 3: bouncy start from IDLE
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        k = 1'b1;
        for (int i = 0; i < 15; i++) begin
            key_start = k;
            tick(2);
            k = ~k;
        end
        check("bounce_no_event", state, 3'd0);
        key_start = 1'b1;
        tick(12);
        check("bounce_one_press", {sw_en, state}, {1'b1, 3'd1});
        key_start = 1'b0;
        tick(15);
        check("bounce_release_no_event", state, 3'd1);

        // 4: pause / resume / stop-from-hold, expectations queued in order
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        press_key(1);
        e = exp_q.pop_front();
        check("pause_to_hold", state, e);
        check("hold_levels", {sw_en, pause, clear}, 3'b110);
        press_key(1);
        e = exp_q.pop_front();
        check("pause_to_run", state, e);
        check("run_levels", {sw_en, pause, clear}, 3'b100);
        press_key(1);
        e = exp_q.pop_front();
        check("pause_to_hold_again", state, e);
        press_key(0);
        check("hold_start_stop", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd3));

        // 5a: from RUN, start and clear together -> clear wins, start dropped
        press_key(0);
        check("stop_to_run", state, 3'd1);
        key_start = 1'b1;
        key_clear = 1'b1;
        tick(7);
        check("clr_pre_edge", {clear, state}, {1'b0, 3'd1});
        tick(1);
        check("clr_entered", {sw_en, pause, clear, state}, outs(0, 0, 1, 3'd4));
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!clear) break;
            n++;
        end
        check("clr_width", n, CLR);
        check("clr_exit_idle", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd0));
        key_start = 1'b0;
        key_clear = 1'b0;
        tick(12);
        check("clr_start_discarded", state, 3'd0);

        // 5b: start pulse arriving mid-CLEAR is ignored
        key_clear = 1'b1;
        tick(3);
        key_start = 1'b1;
        tick(6);
        check("clr_mid_state", {clear, state}, {1'b1, 3'd4});
        tick(3);
        key_clear = 1'b0;
        key_start = 1'b0;
        tick(20);
        check("clr_start_ignored", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd0));

        // 6: reset on the 3rd cycle of CLEAR, held pause through reset
        key_clear = 1'b1;
        tick(8);
        check("clr6_entered", state, 3'd4);
        tick(2);
        key_clear = 1'b0;
        #3;
        rst_n = 1'b0;
        key_pause = 1'b1;
        #1;
        check("async_reset_clear", {clear, state}, {1'b0, 3'd0});
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("held_pause_idle", {sw_en, pause, clear, state}, outs(0, 0, 0, 3'd0));
        key_pause = 1'b0;
        tick(10);
        check("pause_release_idle", state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
